// File: rtl/bmult_share_sched.sv
// bmult_share_sched: round-robin scheduler sharing one external fixed-latency
// WIDTH x WIDTH unsigned multiplier among NREQ requesters. Results are buffered
// in a credit-protected FIFO, so response backpressure never drops a product.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  per-requester handshake (req_ready is combinational)
//   req_a/req_b          packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready  response handshake on the FIFO head
//   rsp_id/rsp_p         requester index and product at the FIFO head
//   mult_a/mult_b        registered operands to the multiplier
//   mult_p               multiplier product, MULT_LAT cycles after mult_a/mult_b
//   busy                 any transaction in flight or buffered
module bmult_share_sched #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned WIDTH      = 26,
    parameter int unsigned MULT_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [2*WIDTH-1:0]    rsp_p,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    input  logic [2*WIDTH-1:0]    mult_p,
    output logic                  busy
);

    localparam int unsigned PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PRODW = 2 * WIDTH;

    logic [IDW-1:0]              ptr_q;
    logic [WIDTH-1:0]            mult_a_q, mult_b_q;
    logic [MULT_LAT:0]           tag_vld_q;
    logic [MULT_LAT:0][IDW-1:0]  tag_id_q;
    logic [IDW-1:0]              mem_id_q [FIFO_DEPTH];
    logic [PRODW-1:0]            mem_p_q  [FIFO_DEPTH];
    logic [PW-1:0]               wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]               fifo_cnt_q, fifo_cnt_d;
    logic [CW-1:0]               out_cnt_q, out_cnt_d;
    logic                        busy_q;

    logic                        credit_ok_c;
    logic                        gnt_c;
    logic [IDW-1:0]              gnt_idx_c;
    logic [IDW-1:0]              cand_c;
    logic                        cap_c;
    logic                        pop_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit counts in-flight tags plus FIFO occupancy; a same-cycle pop is ignored.
    assign credit_ok_c = rst_n && (out_cnt_q < CW'(FIFO_DEPTH));

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_c     = 1'b0;
        gnt_idx_c = '0;
        cand_c    = '0;
        req_ready = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand_c = IDW'((32'(ptr_q) + i) % NREQ);
            if (!gnt_c && credit_ok_c && req_valid[cand_c]) begin
                gnt_c     = 1'b1;
                gnt_idx_c = cand_c;
            end
        end
        if (gnt_c) begin
            req_ready[gnt_idx_c] = 1'b1;
        end
    end

    assign cap_c      = tag_vld_q[MULT_LAT];
    assign pop_c      = rsp_valid && rsp_ready;
    assign out_cnt_d  = out_cnt_q + CW'(gnt_c) - CW'(pop_c);
    assign fifo_cnt_d = fifo_cnt_q + CW'(cap_c) - CW'(pop_c);

    assign rsp_valid = (fifo_cnt_q != '0);
    assign rsp_id    = mem_id_q[rd_ptr_q];
    assign rsp_p     = mem_p_q[rd_ptr_q];
    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;
    assign busy      = busy_q;

    // Issue, tag pipeline, result FIFO and credit bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= IDW'(NREQ - 1);
            mult_a_q   <= '0;
            mult_b_q   <= '0;
            tag_vld_q  <= '0;
            tag_id_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            out_cnt_q  <= '0;
            busy_q     <= 1'b0;
            for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
                mem_id_q[k] <= '0;
                mem_p_q[k]  <= '0;
            end
        end else begin
            if (gnt_c) begin
                ptr_q    <= gnt_idx_c;
                mult_a_q <= req_a[32'(gnt_idx_c) * WIDTH +: WIDTH];
                mult_b_q <= req_b[32'(gnt_idx_c) * WIDTH +: WIDTH];
            end
            tag_vld_q <= {tag_vld_q[MULT_LAT-1:0], gnt_c};
            tag_id_q  <= {tag_id_q[MULT_LAT-1:0], gnt_idx_c};
            // Credit guarantees a free slot here, even when a pop shares the cycle.
            if (cap_c) begin
                mem_id_q[wr_ptr_q] <= tag_id_q[MULT_LAT];
                mem_p_q[wr_ptr_q]  <= mult_p;
                wr_ptr_q           <= ptr_inc(wr_ptr_q);
            end
            if (pop_c) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            fifo_cnt_q <= fifo_cnt_d;
            out_cnt_q  <= out_cnt_d;
            busy_q     <= (out_cnt_d != '0);
        end
    end

endmodule
